// File: rtl/bcd_gray_stimulus_sequencer.sv
// Back-pressurable stimulus source for the BCD<->Gray converter: one sweep of BCD digits, then their Gray codes.
// Optional feature macro: SWEEP_CNT_EN adds the sweep_count[7:0] completed-sweep counter port.
module bcd_gray_stimulus_sequencer #(
  parameter int unsigned DIGIT_MAX  = 9,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] bcd,
  output logic [3:0] gray,
  output logic       mode,
  output logic       busy,
  output logic       done
`ifdef SWEEP_CNT_EN
  ,
  output logic [7:0] sweep_count
`endif
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] DMAX     = DW'(DIGIT_MAX);
  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYCLES - 1);
  localparam bit            HAS_GAP  = (GAP_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_BCD,
    S_RUN_GRAY,
    S_GAP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [DW-1:0] gap_q, gap_d;
  logic [DW-1:0] bcd_q, bcd_d;
  logic [DW-1:0] gray_q, gray_d;
  logic          valid_q, valid_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          xfer;
  logic [DW-1:0] nxt_digit;
  logic          nxt_mode;

  assign xfer = valid_q & out_ready;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    gap_d     = gap_q;
    bcd_d     = bcd_q;
    gray_d    = gray_q;
    valid_d   = valid_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nxt_digit = digit_q + 4'd1;
    nxt_mode  = mode_q;
    // Last BCD digit rolls the sweep over into the Gray phase at digit 0
    if ((state_q == S_RUN_BCD) && (digit_q == DMAX)) begin
      nxt_digit = '0;
      nxt_mode  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN_BCD;
          digit_d = '0;
          bcd_d   = '0;
          gray_d  = '0;
          mode_d  = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN_BCD, S_RUN_GRAY: begin
        if (xfer) begin
          if ((state_q == S_RUN_GRAY) && (digit_q == DMAX)) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            bcd_d   = '0;
            gray_d  = '0;
            mode_d  = 1'b0;
            digit_d = '0;
          end else begin
            digit_d = nxt_digit;
            mode_d  = nxt_mode;
            bcd_d   = nxt_mode ? '0 : nxt_digit;
            gray_d  = nxt_mode ? (nxt_digit ^ (nxt_digit >> 1)) : '0;
            valid_d = !HAS_GAP;
            gap_d   = GAP_LAST;
            state_d = HAS_GAP ? S_GAP : (nxt_mode ? S_RUN_GRAY : S_RUN_BCD);
          end
        end
      end
      // Next item is already loaded; only valid is withheld
      S_GAP: begin
        if (gap_q == '0) begin
          valid_d = 1'b1;
          state_d = mode_q ? S_RUN_GRAY : S_RUN_BCD;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      digit_d = '0;
      gap_d   = '0;
      bcd_d   = '0;
      gray_d  = '0;
      mode_d  = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      digit_q <= '0;
      gap_q   <= '0;
      bcd_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      gap_q   <= gap_d;
      bcd_q   <= bcd_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign bcd       = bcd_q;
  assign gray      = gray_q;
  assign mode      = mode_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef SWEEP_CNT_EN
  logic [CW-1:0] sweep_cnt_q;

  // Counts only sweeps that reach DONE; aborted sweeps never get there
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      sweep_cnt_q <= sweep_cnt_q + 8'd1;
    end
  end

  assign sweep_count = sweep_cnt_q;
`endif

endmodule

// File: tb/tb_bcd_gray_stimulus_sequencer.sv
// Bench for bcd_gray_stimulus_sequencer: directed steps plus randomized back-pressure and aborts against an item-list model.
module tb_bcd_gray_stimulus_sequencer;

  localparam int NITEMS = 20;
  localparam int DMAX   = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_b, abort_b, ready_b;
  logic       v0, v1, mo0, mo1, bz0, bz1, dn0, dn1;
  logic [3:0] b0, b1, g0, g1;
  logic       sel;
  logic       ov, om, obz, odn;
  logic [3:0] ob, og;
  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;
  int         exp_sc [2];
  int         gray_tab [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};

`ifdef SWEEP_CNT_EN
  logic [7:0] sc0, sc1;
`endif

  always #5 clk = ~clk;

  bcd_gray_stimulus_sequencer #(.DIGIT_MAX(DMAX), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_b[0]), .abort(abort_b[0]), .out_ready(ready_b[0]),
    .out_valid(v0), .bcd(b0), .gray(g0), .mode(mo0), .busy(bz0), .done(dn0)
`ifdef SWEEP_CNT_EN
    , .sweep_count(sc0)
`endif
  );

  bcd_gray_stimulus_sequencer #(.DIGIT_MAX(DMAX), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_b[1]), .abort(abort_b[1]), .out_ready(ready_b[1]),
    .out_valid(v1), .bcd(b1), .gray(g1), .mode(mo1), .busy(bz1), .done(dn1)
`ifdef SWEEP_CNT_EN
    , .sweep_count(sc1)
`endif
  );

  assign ov  = sel ? v1  : v0;
  assign ob  = sel ? b1  : b0;
  assign og  = sel ? g1  : g0;
  assign om  = sel ? mo1 : mo0;
  assign obz = sel ? bz1 : bz0;
  assign odn = sel ? dn1 : dn0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Item i of a sweep: BCD digits first, then Gray codes of 0..DMAX
  function automatic logic [8:0] exp_item(input int i);
    if (i <= DMAX) return {4'(i), 4'd0, 1'b0};
    return {4'd0, 4'(gray_tab[i - (DMAX + 1)]), 1'b1};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(ov), 0);
    chk({tag, "_busy"}, 32'(obz), 0);
    chk({tag, "_done"}, 32'(odn), 0);
    chk({tag, "_data"}, 32'({ob, og, om}), 0);
  endtask

  // One sweep on DUT s; stall_idx / abort_idx < 0 disable those events
  task automatic sweep(input int s, input int gap, input int pct, input int stall_idx, input int abort_idx);
    int idx, gap_left, cyc, stall_n;
    idx = 0; gap_left = 0; cyc = 0; stall_n = 0;
    sel = s[0];
    abort_b[s] = 1'b1;
    @(negedge clk);
    abort_b[s] = 1'b0;
    chk("pre_busy", 32'(obz), 0);
    start_b[s] = 1'b1;
    ready_b[s] = 1'b0;
    @(negedge clk);
    start_b[s] = 1'b0;
    while (idx < NITEMS && cyc < 1000) begin
      chk("run_busy", 32'(obz), 1);
      if (gap_left > 0) begin
        chk("gap_valid", 32'(ov), 0);
        gap_left--;
        ready_b[s] = 1'($urandom_range(0, 1));
      end else begin
        chk("valid", 32'(ov), 1);
        chk("item", 32'({ob, og, om}), 32'(exp_item(idx)));
        if (idx == abort_idx) begin
          abort_b[s] = 1'b1;
          ready_b[s] = 1'($urandom_range(0, 1));
          @(negedge clk);
          abort_b[s] = 1'b0;
          ready_b[s] = 1'b0;
          chk_quiet("abort");
          @(negedge clk);
          chk("abort_no_done", 32'(odn), 0);
          return;
        end
        if (idx == stall_idx && stall_n < 5) begin
          ready_b[s] = 1'b0;
          stall_n++;
        end else begin
          ready_b[s] = 1'($urandom_range(0, 99) < pct);
        end
        if (ready_b[s]) begin
          idx++;
          if (idx < NITEMS) gap_left = gap;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ready_b[s] = 1'b0;
    chk("items_done", 32'(idx), NITEMS);
    if (pct == 100 && stall_idx < 0) chk("sweep_len", 32'(cyc), 32'(NITEMS + (NITEMS - 1) * gap));
    chk("done_pulse", 32'(odn), 1);
    chk("done_valid", 32'(ov), 0);
    chk("done_busy", 32'(obz), 1);
    exp_sc[s]++;
    start_b[s] = 1'b1;
    @(negedge clk);
    start_b[s] = 1'b0;
    chk_quiet("post_done");
    @(negedge clk);
    chk("start_in_done_ignored", 32'(obz), 0);
  endtask

  initial begin
    int s;
    sel = 1'b0;
    exp_sc[0] = 0;
    exp_sc[1] = 0;
    rst = 1'b1;
    start_b = 2'b11;
    abort_b = 2'b00;
    ready_b = 2'b00;
    repeat (2) begin
      @(negedge clk);
      sel = 1'b0; #0 chk_quiet("reset0");
      sel = 1'b1; #0 chk_quiet("reset1");
    end
    rst = 1'b0;
    start_b = 2'b00;
    @(negedge clk);
    chk("start_during_rst_ignored", 32'({bz1, bz0}), 0);

    sweep(0, 0, 100, -1, -1);
    sweep(0, 0, 100, 3, -1);
    sweep(0, 0, 100, -1, 15);
    sweep(0, 0, 70, -1, -1);
    sweep(1, 2, 100, -1, -1);
    sweep(1, 2, 60, -1, -1);
    sweep(1, 2, 100, -1, 12);
    for (int k = 0; k < 6; k++) begin
      s = int'($urandom_range(0, 1));
      sweep(s, (s == 1) ? 2 : 0, int'($urandom_range(30, 90)), -1, int'($urandom_range(0, 30)));
    end

    // Reset in the middle of a sweep
    sel = 1'b1;
    start_b[1] = 1'b1;
    @(negedge clk);
    start_b[1] = 1'b0;
    ready_b[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(obz), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_b[1] = 1'b0;
    chk_quiet("mid_rst");
    exp_sc[0] = 0;
    exp_sc[1] = 0;
    @(negedge clk);
    chk("after_rst_idle", 32'(obz), 0);

`ifdef SWEEP_CNT_EN
    chk("sc0_reset", 32'(sc0), 0);
    sweep(0, 0, 100, -1, -1);
    sweep(0, 0, 100, -1, 7);
    sweep(0, 0, 100, -1, -1);
    chk("sc0_two", 32'(sc0), 32'(8'(exp_sc[0])));
    chk("sc1_zero", 32'(sc1), 32'(8'(exp_sc[1])));
    repeat (254) sweep(0, 0, 100, -1, -1);
    chk("sc0_wrap", 32'(sc0), 32'(8'(exp_sc[0])));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
